plic_claim_ctrl: RTL

- Per-target PLIC controller that sequences the per-source gateways.
- Selects the highest-priority pending, enabled source and raises the target interrupt when that priority exceeds the threshold.
- Services claim and complete requests from the register interface, returning the claimed ID and issuing one-cycle claim/complete pulses to the addressed gateway.
- One instance per target; sits between the gateway array and the register file.

---
 rtl/plic_claim_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/plic_claim_ctrl.sv
// Per-target PLIC claim/complete controller: priority select, irq, claim FSM, gateway pulses.
// Optional outstanding-claim tracking with illegal-complete flag under `PLIC_CLAIM_TRACK_EN.
module plic_claim_ctrl #(
  parameter int SRC_NUM    = 32,
  parameter int PRIO_WIDTH = 3,
  parameter int ID_WIDTH   = $clog2(SRC_NUM+1)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [SRC_NUM-1:0]               ip_i,
  input  logic [SRC_NUM-1:0]               ie_i,
  input  logic [SRC_NUM*PRIO_WIDTH-1:0]    prio_i,
  input  logic [PRIO_WIDTH-1:0]            thold_i,
  input  logic                             claim_req_i,
  output logic                             claim_rdy_o,
  output logic                             claim_vld_o,
  output logic [ID_WIDTH-1:0]              claim_id_o,
  input  logic                             comp_req_i,
  input  logic [ID_WIDTH-1:0]              comp_id_i,
  output logic [SRC_NUM-1:0]               clam_o,
  output logic [SRC_NUM-1:0]               comp_o,
  output logic                             irq_o,
  output logic                             comp_err_o
);

  typedef enum logic [1:0] {IDLE, CLAIM, SETTLE} state_e;

  localparam logic [SRC_NUM-1:0] ONE = {{(SRC_NUM-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ID_WIDTH-1:0]   best_id_q, best_id_d;
  logic [PRIO_WIDTH-1:0] best_prio_q, best_prio_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic                  rdy_q, rdy_d, vld_q, vld_d, irq_q, irq_d;
  logic [SRC_NUM-1:0]    clam_q, clam_d, comp_q, comp_d;
  logic [SRC_NUM-1:0]    comp_oh;
  logic                  comp_ok, hit;
`ifdef PLIC_CLAIM_TRACK_EN
  logic [SRC_NUM-1:0]    outst_q, outst_d;
  logic                  err_q, err_d, comp_fwd;
`endif

  // Descending scan with >= so a priority tie settles on the lowest ID.
  always_comb begin
    best_id_d   = '0;
    best_prio_d = '0;
    for (int k = SRC_NUM-1; k >= 0; k--) begin
      if (ip_i[k] && ie_i[k] && (prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] != '0) &&
          (prio_i[k*PRIO_WIDTH +: PRIO_WIDTH] >= best_prio_d)) begin
        best_prio_d = prio_i[k*PRIO_WIDTH +: PRIO_WIDTH];
        best_id_d   = ID_WIDTH'(k+1);
      end
    end
  end

  assign hit = best_prio_q > thold_i;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    vld_d   = 1'b0;
    clam_d  = '0;
    unique case (state_q)
      IDLE: if (claim_req_i && rdy_q) begin
        state_d = CLAIM;
        vld_d   = 1'b1;
        id_d    = hit ? best_id_q : '0;
        if (hit) clam_d = ONE << (best_id_q - ID_WIDTH'(1));
      end
      CLAIM:   state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
    irq_d = hit && (state_q == IDLE);
  end

  always_comb begin
    comp_oh = ONE << (comp_id_i - ID_WIDTH'(1));
    comp_ok = comp_req_i && (comp_id_i != '0) && (comp_id_i <= ID_WIDTH'(SRC_NUM)) &&
              (|(comp_oh & ie_i));
`ifdef PLIC_CLAIM_TRACK_EN
    // Complete checks the pre-claim bit; a same-cycle claim of that ID still sets it.
    comp_fwd = comp_ok && (|(comp_oh & outst_q));
    comp_d   = comp_fwd ? comp_oh : '0;
    err_d    = comp_req_i && !comp_fwd;
    outst_d  = (outst_q & ~comp_d) | clam_d;
`else
    comp_d   = comp_ok ? comp_oh : '0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      best_id_q   <= '0;
      best_prio_q <= '0;
      id_q        <= '0;
      rdy_q       <= 1'b0;
      vld_q       <= 1'b0;
      irq_q       <= 1'b0;
      clam_q      <= '0;
      comp_q      <= '0;
`ifdef PLIC_CLAIM_TRACK_EN
      outst_q     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      id_q        <= id_d;
      rdy_q       <= rdy_d;
      vld_q       <= vld_d;
      irq_q       <= irq_d;
      clam_q      <= clam_d;
      comp_q      <= comp_d;
`ifdef PLIC_CLAIM_TRACK_EN
      outst_q     <= outst_d;
      err_q       <= err_d;
`endif
    end
  end

  assign claim_rdy_o = rdy_q;
  assign claim_vld_o = vld_q;
  assign claim_id_o  = id_q;
  assign clam_o      = clam_q;
  assign comp_o      = comp_q;
  assign irq_o       = irq_q;
`ifdef PLIC_CLAIM_TRACK_EN
  assign comp_err_o  = err_q;
`else
  assign comp_err_o  = 1'b0;
`endif

endmodule
